// File: rtl/sdram_frame_loader.sv
// Packs a byte stream into 16-bit words and writes one full frame into an SDRAM slot.
// The slot base comes from the frame ID that is latched at start.
module sdram_frame_loader #(
    parameter int WORDS_PER_LINE = 512,
    parameter int LINES          = 768,
    parameter int FRAME_ID_W     = 6,
    parameter int WORD_ADDR_W    = 19
) (
    input  logic                              iCLK,
    input  logic                              iRST_N,
    input  logic                              iSTART,
    input  logic [FRAME_ID_W-1:0]             iFRAME_ID,
    input  logic [7:0]                        iBYTE,
    input  logic                              iBYTE_VALID,
    output logic                              oBYTE_READY,
    input  logic                              iWAIT_REQUEST,
    output logic                              oWR_EN,
    output logic [FRAME_ID_W+WORD_ADDR_W-1:0] oWR_ADDR,
    output logic [15:0]                       oWR_DATA,
    output logic                              oBUSY,
    output logic                              oDONE,
    output logic                              oLINE_DONE,
    output logic [2:0]                        oSTATE
);

    // Handshakes: a byte moves on a cycle with iBYTE_VALID & oBYTE_READY; a word moves on a
    // cycle with oWR_EN & ~iWAIT_REQUEST. Address and data hold until the word moves.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW   = 3'd1,
        S_HIGH  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [WORD_ADDR_W-1:0] LAST_WORD = WORD_ADDR_W'(WORDS_PER_LINE * LINES - 1);
    localparam logic [COL_W-1:0]       LAST_COL  = COL_W'(WORDS_PER_LINE - 1);

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_ID_W-1:0]   frame_id;
    logic [WORD_ADDR_W-1:0]  counter;
    logic [COL_W-1:0]        col;
    logic [15:0]             data;
    logic                    line_done;
    logic                    start_ok;
    logic                    byte_ok;
    logic                    word_ok;

    assign start_ok = iSTART && (state == S_IDLE || state == S_DONE);
    assign byte_ok  = iBYTE_VALID && oBYTE_READY;
    assign word_ok  = (state == S_WRITE) && !iWAIT_REQUEST;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_LOW;
            S_LOW:   if (byte_ok) state_next = S_HIGH;
            S_HIGH:  if (byte_ok) state_next = S_WRITE;
            S_WRITE: if (word_ok) state_next = (counter == LAST_WORD) ? S_DONE : S_LOW;
            S_DONE:  if (start_ok) state_next = S_LOW;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBYTE_READY = (state == S_LOW) || (state == S_HIGH);
        oWR_EN      = (state == S_WRITE);
        oBUSY       = (state == S_LOW) || (state == S_HIGH) || (state == S_WRITE);
        oDONE       = (state == S_DONE);
        oSTATE      = state;
    end

    // The column counter tracks the position within a line so end-of-line needs no divider.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            frame_id  <= '0;
            counter   <= '0;
            col       <= '0;
            data      <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= word_ok && (col == LAST_COL);
            if (start_ok) begin
                frame_id <= iFRAME_ID;
                counter  <= '0;
                col      <= '0;
            end else if (word_ok) begin
                if (counter != LAST_WORD) begin
                    counter <= counter + 1'b1;
                end
                col <= (col == LAST_COL) ? '0 : col + 1'b1;
            end
            if (byte_ok && state == S_LOW) begin
                data[7:0] <= iBYTE;
            end
            if (byte_ok && state == S_HIGH) begin
                data[15:8] <= iBYTE;
            end
        end
    end

    assign oWR_ADDR   = {frame_id, counter};
    assign oWR_DATA   = data;
    assign oLINE_DONE = line_done;

endmodule

// File: tb/tb_sdram_frame_loader.sv
// Bench for sdram_frame_loader on a small 4x2-word frame, with randomized byte gaps and wait states
// scored against a word list built from the byte stream.
module tb_sdram_frame_loader;

    localparam int WPL   = 4;
    localparam int LINES = 2;
    localparam int FW    = 6;
    localparam int AW    = 19;
    localparam int NW    = WPL * LINES;
    localparam int NB    = 2 * NW;
    localparam int RW    = FW + AW + 16;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iSTART = 1'b0;
    logic [FW-1:0] iFRAME_ID = '0;
    logic [7:0]    iBYTE = '0;
    logic          iBYTE_VALID = 1'b0;
    logic          iWAIT_REQUEST = 1'b0;
    logic          oBYTE_READY;
    logic          oWR_EN;
    logic [FW+AW-1:0] oWR_ADDR;
    logic [15:0]   oWR_DATA;
    logic          oBUSY;
    logic          oDONE;
    logic          oLINE_DONE;
    logic [2:0]    oSTATE;

    sdram_frame_loader #(
        .WORDS_PER_LINE(WPL), .LINES(LINES), .FRAME_ID_W(FW), .WORD_ADDR_W(AW)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iFRAME_ID(iFRAME_ID),
        .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID), .oBYTE_READY(oBYTE_READY),
        .iWAIT_REQUEST(iWAIT_REQUEST), .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
        .oWR_DATA(oWR_DATA), .oBUSY(oBUSY), .oDONE(oDONE), .oLINE_DONE(oLINE_DONE),
        .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor records, sampled on the falling edge
    logic [RW-1:0] got_q[$];
    int            ld_q[$];
    int            stab_bad = 0;
    int            rdy_bad = 0;
    int            wait_cyc = 0;
    int            busy_cyc = 0;
    logic          prev_acc = 1'b0;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_off = '0;
    logic [FW+AW-1:0] prev_addr = '0;
    logic [15:0]   prev_data = '0;

    always @(negedge iCLK) begin
        if (!iRST_N) begin
            prev_acc  = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (oLINE_DONE) ld_q.push_back(prev_acc ? int'(prev_off) : -1);
            if (oWR_EN && prev_wait && (oWR_ADDR != prev_addr || oWR_DATA != prev_data)) stab_bad++;
            if (oWR_EN && oBYTE_READY) rdy_bad++;
            if (oWR_EN && iWAIT_REQUEST) wait_cyc++;
            if (oBUSY) busy_cyc++;
            prev_acc = oWR_EN && !iWAIT_REQUEST;
            if (prev_acc) got_q.push_back({oWR_ADDR, oWR_DATA});
            prev_off  = oWR_ADDR[AW-1:0];
            prev_wait = oWR_EN && iWAIT_REQUEST;
            prev_addr = oWR_ADDR;
            prev_data = oWR_DATA;
        end
    end

    // Wait-request driver: 0 none, 1 hold one word for 5 cycles, 2 random, 3 always high
    int wait_mode = 0;
    int hold_word = 0;
    int hold_cnt  = 0;

    always begin
        @(posedge iCLK);
        #1;
        if (wait_mode == 1 && oWR_EN && int'(oWR_ADDR[AW-1:0]) == hold_word) begin
            iWAIT_REQUEST = (hold_cnt < 5);
            if (hold_cnt < 5) hold_cnt++;
        end else begin
            hold_cnt = 0;
            case (wait_mode)
                2:       iWAIT_REQUEST = ($urandom_range(0, 99) < 40);
                3:       iWAIT_REQUEST = 1'b1;
                default: iWAIT_REQUEST = 1'b0;
            endcase
        end
    end

    task automatic stream_frame(input int fid, input bit seq_bytes, input int valid_pct,
                                input int restart_at, input int exp_busy);
        logic [7:0]    b[NB];
        logic [RW-1:0] exp_q[$];
        int            exp_ld[$];
        int            base, ld_base, busy_base, idx, cyc;
        bit            restarted;
        logic [FW+AW-1:0] a;
        for (int i = 0; i < NB; i++) b[i] = seq_bytes ? 8'(i) : 8'($urandom);
        for (int k = 0; k < NW; k++) begin
            a = (FW+AW)'(fid * (1 << AW) + k);
            exp_q.push_back({a, b[2*k+1], b[2*k]});
            if (k % WPL == WPL - 1) exp_ld.push_back(k);
        end
        base      = got_q.size();
        ld_base   = ld_q.size();
        busy_base = busy_cyc;

        @(posedge iCLK); #1;
        iSTART = 1'b1; iFRAME_ID = FW'(fid);
        @(posedge iCLK); #1;
        iSTART = 1'b0; iFRAME_ID = FW'($urandom);
        iBYTE = b[0];
        iBYTE_VALID = ($urandom_range(0, 99) < valid_pct);
        @(negedge iCLK);
        n_cmp++;
        if (oBUSY !== 1'b1 || oDONE !== 1'b0) begin
            n_err++;
            $display("FAIL start_flags fid=%0d: busy=%b done=%b want busy=1 done=0", fid, oBUSY, oDONE);
        end
        idx = 0; cyc = 0; restarted = 0;
        while (idx < NB && cyc < 500) begin
            if (iBYTE_VALID && oBYTE_READY) idx++;
            @(posedge iCLK); #1;
            cyc++;
            iSTART = 1'b0;
            if (restart_at >= 0 && idx == restart_at && !restarted) begin
                iSTART = 1'b1; iFRAME_ID = 6'd9; restarted = 1;
            end
            iBYTE_VALID = (idx < NB) && ($urandom_range(0, 99) < valid_pct);
            iBYTE = (idx < NB) ? b[idx] : 8'($urandom);
            @(negedge iCLK);
        end
        iSTART = 1'b0;
        iBYTE_VALID = 1'b0;
        n_cmp++;
        if (idx !== NB) begin
            n_err++;
            $display("FAIL byte_feed fid=%0d: consumed %0d want %0d", fid, idx, NB);
        end
        cyc = 0;
        while (!oDONE && cyc < 100) begin
            @(negedge iCLK);
            cyc++;
        end
        @(posedge iCLK); #1;
        n_cmp++;
        if (oDONE !== 1'b1 || oBUSY !== 1'b0) begin
            n_err++;
            $display("FAIL done_flags fid=%0d: done=%b busy=%b want done=1 busy=0", fid, oDONE, oBUSY);
        end
        n_cmp++;
        if (got_q.size() - base !== NW) begin
            n_err++;
            $display("FAIL write_count fid=%0d: got %0d want %0d", fid, got_q.size() - base, NW);
        end
        for (int k = 0; k < NW && base + k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[base+k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL word%0d fid=%0d: got addr=%h data=%h want addr=%h data=%h", k, fid,
                         got_q[base+k][RW-1:16], got_q[base+k][15:0], exp_q[k][RW-1:16], exp_q[k][15:0]);
            end
        end
        n_cmp++;
        if (ld_q.size() - ld_base !== exp_ld.size()) begin
            n_err++;
            $display("FAIL line_done_count fid=%0d: got %0d want %0d", fid, ld_q.size() - ld_base, exp_ld.size());
        end
        for (int j = 0; j < exp_ld.size() && ld_base + j < ld_q.size(); j++) begin
            n_cmp++;
            if (ld_q[ld_base+j] !== exp_ld[j]) begin
                n_err++;
                $display("FAIL line_done%0d fid=%0d: after word %0d want word %0d", j, fid, ld_q[ld_base+j], exp_ld[j]);
            end
        end
        if (exp_busy > 0) begin
            n_cmp++;
            if (busy_cyc - busy_base !== exp_busy) begin
                n_err++;
                $display("FAIL busy_cycles fid=%0d: got %0d want %0d", fid, busy_cyc - busy_base, exp_busy);
            end
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        n_cmp++;
        if ({oWR_EN, oBUSY, oDONE, oBYTE_READY, oLINE_DONE} !== 5'b0 || oWR_ADDR !== '0 || oWR_DATA !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b busy=%b done=%b rdy=%b ld=%b addr=%h data=%h want all 0",
                     oWR_EN, oBUSY, oDONE, oBYTE_READY, oLINE_DONE, oWR_ADDR, oWR_DATA);
        end
        #2 iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        n_cmp++;
        if (oBUSY !== 1'b0 || oBYTE_READY !== 1'b0 || oWR_EN !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b en=%b want 0", oBUSY, oBYTE_READY, oWR_EN);
        end
    endtask

    task automatic test_sequential_frame();
        wait_mode = 0;
        stream_frame(5, 1, 100, -1, 3 * NW);
    endtask

    task automatic test_wait_hold();
        int w0, s0, r0;
        w0 = wait_cyc; s0 = stab_bad; r0 = rdy_bad;
        wait_mode = 1; hold_word = 2;
        stream_frame(12, 0, 100, -1, 3 * NW + 5);
        wait_mode = 0;
        n_cmp++;
        if (wait_cyc - w0 !== 5) begin
            n_err++;
            $display("FAIL wait_cycles: got %0d want 5", wait_cyc - w0);
        end
        n_cmp++;
        if (stab_bad - s0 !== 0 || rdy_bad - r0 !== 0) begin
            n_err++;
            $display("FAIL hold_stable: unstable=%0d ready_in_write=%0d want 0/0", stab_bad - s0, rdy_bad - r0);
        end
    endtask

    task automatic test_valid_gaps();
        wait_mode = 0;
        stream_frame(5, 1, 50, -1, 0);
    endtask

    task automatic test_restart_ignored();
        int s0;
        wait_mode = 0;
        stream_frame(5, 0, 100, 6, 3 * NW);
        s0 = stab_bad;
        wait_mode = 2;
        stream_frame(63, 0, 70, -1, 0);
        wait_mode = 0;
        n_cmp++;
        if (stab_bad - s0 !== 0) begin
            n_err++;
            $display("FAIL random_wait_stable: unstable=%0d want 0", stab_bad - s0);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc, base;
        wait_mode = 3;
        @(posedge iCLK); #1;
        iSTART = 1'b1; iFRAME_ID = 6'd33;
        @(posedge iCLK); #1;
        iSTART = 1'b0; iBYTE_VALID = 1'b1; iBYTE = 8'($urandom);
        cyc = 0;
        while (!oWR_EN && cyc < 20) begin
            @(posedge iCLK); #1;
            iBYTE = 8'($urandom);
            cyc++;
        end
        iBYTE_VALID = 1'b0;
        n_cmp++;
        if (oWR_EN !== 1'b1) begin
            n_err++;
            $display("FAIL reach_write: wr_en=%b want 1 within 20 cycles", oWR_EN);
        end
        base = got_q.size();
        @(negedge iCLK); #2;
        iRST_N = 1'b0;
        #1;
        n_cmp++;
        if ({oWR_EN, oBUSY, oDONE, oBYTE_READY} !== 4'b0) begin
            n_err++;
            $display("FAIL async_abort: en=%b busy=%b done=%b rdy=%b want 0", oWR_EN, oBUSY, oDONE, oBYTE_READY);
        end
        repeat (2) @(negedge iCLK);
        #2 iRST_N = 1'b1;
        wait_mode = 0;
        iBYTE_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge iCLK); #1;
            iBYTE = 8'($urandom);
        end
        iBYTE_VALID = 1'b0;
        @(negedge iCLK);
        n_cmp++;
        if (got_q.size() !== base || oBUSY !== 1'b0 || oDONE !== 1'b0 || oBYTE_READY !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_quiet: writes=%0d busy=%b done=%b rdy=%b want 0 writes, all 0",
                     got_q.size() - base, oBUSY, oDONE, oBYTE_READY);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_frame();
        test_wait_hold();
        test_valid_gaps();
        test_restart_ignored();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
